mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one synchronous, 1-cycle-latency word memory between two requesters: port 0 is the CPU core memory port; port 1 is a DMA/debug master.
- Each requester uses the CPU-style handshake: hold req/we/addr/wdata stable until a single-cycle ready, with rdata valid in that same cycle.
- The arbiter grants one access at a time using round-robin, drives the memory, and routes the response back only to its owner.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- p0_req  in  1  port 0 request.
- p0_we  in  1  port 0 write enable.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  XLEN  port 0 write data.
- p0_rdata  out  XLEN  port 0 read data, valid when p0_ready=1.
- p0_ready  out  1  port 0 completion pulse.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ready: same as port 0, for port 1.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, valid the cycle after mem_en with mem_we=0.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- State machine: IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered or decoded from state only; there is no combinational path from req to mem_en.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both high: grant the port named by rr_ptr.
  - On a grant: latch the owner's we/addr/wdata into the command registers, set grant, go to ISSUE.
- ISSUE:
  - mem_en=1 for exactly this cycle, with mem_we/mem_addr/mem_wdata from the command registers.
  - Go to RESP.
- RESP:
  - Sample mem_rdata and drive it onto the owner's rdata.
  - If owner req is still 1: owner ready=1 for this cycle only.
  - If owner req is 0 (aborted): no ready pulse, but a write already issued still completes in memory.
  - In every case: rr_ptr := other port, grant := 00, go to IDLE.
- Latency: req high at IDLE edge N gives mem_en at N+1 and ready at N+2. Maximum throughput is one access per 3 cycles; a port holding req continuously is served every 3 cycles if alone.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1. A requester waits at most one other access (≤6 cycles from req to ready).
- Non-owner: ready=0 at all times. Its rdata holds its last value. Its req changes during another port's access are ignored until the next IDLE.
- Owner req, we, addr and wdata changes after grant are ignored, because the command is latched.
- Writes: ready pulses in RESP as for reads. rdata in that cycle equals mem_rdata and is don't-care to the requester.
- Addresses pass through unmodified; addr[1:0] is not checked.
- Reset, including mid-access: state=IDLE, rr_ptr=port 0, grant=00, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, p0/p1_ready=0, p0/p1_rdata=0.
  - Any in-flight response is discarded.
  - A write whose mem_en was already issued is not undone.

Test Plan:
- Single read: memory word 0x80 = 0xDEADBEEF; p0 read 0x200 held at cycle N → mem_en=1, mem_we=0, mem_addr=0x200 at N+1; p0_ready=1, p0_rdata=0xDEADBEEF at N+2; p1_ready never asserted.
- Write then read: p1 writes 0x12345678 to 0x300, then reads it back → one mem_en with mem_we=1, mem_wdata=0x12345678; p1_ready pulses for each access; readback returns 0x12345678.
- Contention: both ports request continuously from reset for 12 cycles → grant sequence 01,10,01,10; each port gets 2 ready pulses; no two mem_en in consecutive cycles.
- Abort: p0 drops req in ISSUE → no p0_ready; next IDLE grants a pending p1; rr_ptr still advances to port 1.
- Reset mid-access: assert rst during RESP → next cycle all outputs 0, grant=00; first post-reset contention grants port 0.
- Stability: change p0_addr from 0x200 to 0x204 during ISSUE → mem_addr stays 0x200 for the whole access.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle-latency word memory.
// Port 0 is the CPU core port and port 1 is a DMA/debug master. Each access
// takes three cycles: the arbitration decision, the memory strobe, and the
// response. Memory-side outputs and the ready pulses come from registers, so
// no combinational path runs from a request input to the memory strobe.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no access in flight; arbitrate on the incoming requests
// ISSUE | mem_en high for this single cycle with the latched command
// RESP  | mem_rdata valid; routed to the owner, ready pulses if still held
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [XLEN-1:0]   p0_wdata,
   output logic [XLEN-1:0]   p0_rdata,
   output logic              p0_ready,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [XLEN-1:0]   p1_wdata,
   output logic [XLEN-1:0]   p1_rdata,
   output logic              p1_ready,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,

   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t            state;
   logic              rr_ptr;     // port that wins the next tie
   logic              owner;      // port holding the current access
   logic              pick;       // port chosen if a grant happens this cycle
   logic [XLEN-1:0]   hold0;      // last response delivered to port 0
   logic [XLEN-1:0]   hold1;      // last response delivered to port 1

   // Arbitration choice: a lone requester wins, a tie goes to rr_ptr.
   always_comb begin
      pick = p1_req;
      if (p0_req && p1_req)
         pick = rr_ptr;
   end

   // Access sequencer: grant, strobe memory once, then deliver the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         grant     <= 2'b00;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         p0_ready  <= 1'b0;
         p1_ready  <= 1'b0;
         hold0     <= '0;
         hold1     <= '0;
      end else begin
         p0_ready <= 1'b0;
         p1_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (p0_req || p1_req) begin
                  owner  <= pick;
                  grant  <= pick ? 2'b10 : 2'b01;
                  mem_en <= 1'b1;
                  if (pick) begin
                     mem_we    <= p1_we;
                     mem_addr  <= p1_addr;
                     mem_wdata <= p1_wdata;
                  end else begin
                     mem_we    <= p0_we;
                     mem_addr  <= p0_addr;
                     mem_wdata <= p0_wdata;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               // mem_addr/mem_wdata keep the command; only the strobes drop.
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               // An owner that let go of req during the access gets no pulse.
               if (owner)
                  p1_ready <= p1_req;
               else
                  p0_ready <= p0_req;
               state <= RESP;
            end
            RESP: begin
               if (owner)
                  hold1 <= mem_rdata;
               else
                  hold0 <= mem_rdata;
               rr_ptr <= ~owner;
               grant  <= 2'b00;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

   // The owner sees mem_rdata live during RESP; otherwise each port keeps its last value.
   assign p0_rdata = (state == RESP && !owner) ? mem_rdata : hold0;
   assign p1_rdata = (state == RESP &&  owner) ? mem_rdata : hold1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a timestamp-based transaction model.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int XLEN   = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              p0_req, p0_we, p1_req, p1_we;
   logic [ADDR_W-1:0] p0_addr, p1_addr;
   logic [XLEN-1:0]   p0_wdata, p1_wdata, p0_rdata, p1_rdata;
   logic              p0_ready, p1_ready;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata, mem_rdata;
   logic [1:0]        grant;
   logic              busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rdata(p0_rdata), .p0_ready(p0_ready),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rdata(p1_rdata), .p1_ready(p1_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
   );

   function automatic logic [31:0] init_word(int i);
      if (i == 32'h80) return 32'hDEADBEEF;
      return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
   endfunction

   // Memory: 256 words, one-cycle read latency, returns the old word on writes too.
   logic [31:0] mem [256];
   bit          mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         mem_loaded <= 1'b1;
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr[9:2]];
         if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   // Reference model state: expected memory contents and access timestamps.
   logic [31:0] refmem [256];
   int          cyc = 0;
   int          free_at = 0;
   int          start = -100;
   bit          own = 1'b0;
   bit          rr = 1'b0;
   bit          rdy_exp = 1'b0;
   logic        c_we = 1'b0;
   logic [31:0] c_addr = '0, c_wdata = '0, acc_val = '0;
   logic [31:0] last0 = '0, last1 = '0;

   int total = 0;
   int bad = 0;
   bit saw_rdy0, saw_rdy1;
   int wr_hits = 0;
   int consec_en = 0;
   bit prev_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One clock: update the model from the inputs seen at the edge, then check outputs.
   task automatic step();
      bit          r, q0, q1, w0, w1, issue, resp;
      logic [31:0] a0, a1, d0, d1;
      logic [1:0]  exp_g;
      @(posedge clk);
      r = rst; q0 = p0_req; q1 = p1_req; w0 = p0_we; w1 = p1_we;
      a0 = p0_addr; a1 = p1_addr; d0 = p0_wdata; d1 = p1_wdata;
      cyc++;
      if (r) begin
         free_at = cyc + 1; start = -100; rr = 1'b0;
         last0 = '0; last1 = '0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      end else begin
         if (cyc == start + 1) rdy_exp = own ? q1 : q0;
         if (cyc >= free_at && (q0 || q1)) begin
            own     = (q0 && q1) ? rr : q1;
            rr      = !own;
            start   = cyc;
            free_at = cyc + 3;
            c_we    = own ? w1 : w0;
            c_addr  = own ? a1 : a0;
            c_wdata = own ? d1 : d0;
            acc_val = refmem[c_addr[9:2]];
            if (c_we) refmem[c_addr[9:2]] = c_wdata;
         end
      end
      @(negedge clk);
      issue = (cyc == start);
      resp  = (cyc == start + 1);
      if (resp) begin
         if (own) last1 = acc_val;
         else     last0 = acc_val;
      end
      exp_g = (issue || resp) ? (own ? 2'b10 : 2'b01) : 2'b00;
      chk("mem_en",    32'(mem_en),   32'(issue));
      chk("mem_we",    32'(mem_we),   32'(issue && c_we));
      chk("mem_addr",  mem_addr,      c_addr);
      chk("mem_wdata", mem_wdata,     c_wdata);
      chk("grant",     32'(grant),    32'(exp_g));
      chk("busy",      32'(busy),     32'(exp_g != 2'b00));
      chk("p0_ready",  32'(p0_ready), 32'(resp && !own && rdy_exp));
      chk("p1_ready",  32'(p1_ready), 32'(resp && own && rdy_exp));
      chk("p0_rdata",  p0_rdata,      last0);
      chk("p1_rdata",  p1_rdata,      last1);
      saw_rdy0 = p0_ready;
      saw_rdy1 = p1_ready;
      if (mem_en && mem_we && mem_addr == 32'h300 && mem_wdata == 32'h12345678) wr_hits++;
      if (mem_en && prev_en) consec_en++;
      prev_en = mem_en;
   endtask

   task automatic set_p(input int p, input bit req, input bit we,
                        input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
      end else begin
         p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
      end
   endtask

   task automatic access(input int p, input bit we, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd);
      bit got = 1'b0;
      rd = '0;
      set_p(p, 1'b1, we, a, d);
      for (int n = 0; n < 12 && !got; n++) begin
         step();
         if ((p == 0) ? saw_rdy0 : saw_rdy1) begin
            got = 1'b1;
            rd  = (p == 0) ? p0_rdata : p1_rdata;
         end
      end
      chk("access_ready_seen", 32'(got), 32'd1);
      set_p(p, 1'b0, 1'b0, a, d);
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  seq [$];
      logic [1:0]  prev_g;
      int          rdy0_cnt, rdy1_cnt;
      bit          act0, act1;
      logic [31:0] ra;

      for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
      rst = 1'b1;
      set_p(0, 1'b0, 1'b0, '0, '0);
      set_p(1, 1'b0, 1'b0, '0, '0);
      repeat (3) step();
      rst = 1'b0;
      step();

      // Single read from port 0.
      set_p(0, 1'b1, 1'b0, 32'h200, '0);
      step();
      chk("t1_mem_en",   32'(mem_en), 32'd1);
      chk("t1_mem_we",   32'(mem_we), 32'd0);
      chk("t1_mem_addr", mem_addr,    32'h200);
      step();
      chk("t1_p0_ready", 32'(p0_ready), 32'd1);
      chk("t1_p0_rdata", p0_rdata,      32'hDEADBEEF);
      chk("t1_p1_ready", 32'(p1_ready), 32'd0);
      set_p(0, 1'b0, 1'b0, 32'h200, '0);
      repeat (2) step();

      // Port 1 writes then reads back.
      access(1, 1'b1, 32'h300, 32'h12345678, rd);
      access(1, 1'b0, 32'h300, 32'h0, rd);
      chk("t2_write_strobes", 32'(wr_hits), 32'd1);
      chk("t2_readback",      rd,           32'h12345678);
      repeat (2) step();

      // Contention from reset.
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_p(0, 1'b1, 1'b0, 32'h200, '0);
      set_p(1, 1'b1, 1'b0, 32'h300, '0);
      prev_g = 2'b00; rdy0_cnt = 0; rdy1_cnt = 0; consec_en = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (grant != 2'b00 && prev_g == 2'b00) seq.push_back(grant);
         prev_g = grant;
         if (saw_rdy0) rdy0_cnt++;
         if (saw_rdy1) rdy1_cnt++;
      end
      chk("t3_grant_count", 32'(seq.size()), 32'd4);
      while (seq.size() < 4) seq.push_back(2'b00);
      chk("t3_grant0", 32'(seq[0]), 32'b01);
      chk("t3_grant1", 32'(seq[1]), 32'b10);
      chk("t3_grant2", 32'(seq[2]), 32'b01);
      chk("t3_grant3", 32'(seq[3]), 32'b10);
      chk("t3_p0_readies", 32'(rdy0_cnt), 32'd2);
      chk("t3_p1_readies", 32'(rdy1_cnt), 32'd2);
      chk("t3_back_to_back_en", 32'(consec_en), 32'd0);
      set_p(0, 1'b0, 1'b0, '0, '0);
      set_p(1, 1'b0, 1'b0, '0, '0);
      repeat (4) step();

      // Abort by port 0 during ISSUE; the tie that follows must go to port 1.
      set_p(0, 1'b1, 1'b0, 32'h200, '0);
      step();
      chk("t4_issue_grant", 32'(grant), 32'b01);
      set_p(0, 1'b0, 1'b0, 32'h200, '0);
      set_p(1, 1'b1, 1'b0, 32'h300, '0);
      step();
      chk("t4_no_p0_ready", 32'(p0_ready), 32'd0);
      set_p(0, 1'b1, 1'b0, 32'h200, '0);
      step();
      chk("t4_idle_grant", 32'(grant), 32'b00);
      step();
      chk("t4_tie_to_p1", 32'(grant), 32'b10);
      set_p(0, 1'b0, 1'b0, '0, '0);
      set_p(1, 1'b0, 1'b0, '0, '0);
      repeat (4) step();

      // Reset during RESP.
      set_p(1, 1'b1, 1'b0, 32'h300, '0);
      repeat (2) step();
      chk("t5_in_resp", 32'(p1_ready), 32'd1);
      rst = 1'b1;
      step();
      chk("t5_grant",    32'(grant),    32'b00);
      chk("t5_busy",     32'(busy),     32'd0);
      chk("t5_mem_addr", mem_addr,      32'h0);
      chk("t5_p1_rdata", p1_rdata,      32'h0);
      chk("t5_p1_ready", 32'(p1_ready), 32'd0);
      rst = 1'b0;
      set_p(0, 1'b1, 1'b0, 32'h200, '0);
      step();
      chk("t5_first_grant", 32'(grant), 32'b01);
      set_p(0, 1'b0, 1'b0, '0, '0);
      set_p(1, 1'b0, 1'b0, '0, '0);
      repeat (4) step();

      // Command stability: address change after grant has no effect.
      set_p(0, 1'b1, 1'b0, 32'h200, '0);
      step();
      chk("t6_issue_addr", mem_addr, 32'h200);
      p0_addr = 32'h204;
      step();
      chk("t6_resp_addr", mem_addr, 32'h200);
      chk("t6_rdata",     p0_rdata, 32'hDEADBEEF);
      set_p(0, 1'b0, 1'b0, '0, '0);
      repeat (3) step();

      // Random traffic with aborts, address wobble and occasional reset.
      act0 = 1'b0; act1 = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         step();
         rst = ($urandom_range(0, 399) == 0);
         if (act0 && saw_rdy0) begin
            act0 = 1'b0; p0_req = 1'b0;
         end else if (act0 && $urandom_range(0, 19) == 0) begin
            act0 = 1'b0; p0_req = 1'b0;
         end else if (act0 && $urandom_range(0, 9) == 0) begin
            ra = $urandom_range(0, 1023); p0_addr = ra;
         end else if (!act0 && $urandom_range(0, 2) == 0) begin
            ra = $urandom_range(0, 1023);
            set_p(0, 1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
            act0 = 1'b1;
         end
         if (act1 && saw_rdy1) begin
            act1 = 1'b0; p1_req = 1'b0;
         end else if (act1 && $urandom_range(0, 19) == 0) begin
            act1 = 1'b0; p1_req = 1'b0;
         end else if (act1 && $urandom_range(0, 9) == 0) begin
            ra = $urandom_range(0, 1023); p1_addr = ra;
         end else if (!act1 && $urandom_range(0, 2) == 0) begin
            ra = $urandom_range(0, 1023);
            set_p(1, 1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
            act1 = 1'b1;
         end
      end
      rst = 1'b0;
      set_p(0, 1'b0, 1'b0, '0, '0);
      set_p(1, 1'b0, 1'b0, '0, '0);
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
